adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter BIT_NUM, default 4, the operand/result width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter NUM_REQ, default 4, the number of requesters (legal range 2..16).
REQ-003 The block SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-006 The block SHALL have port req_ready_o  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-007 The block SHALL have port req_op1_i  input  NUM_REQ x BIT_NUM  per-requester first operand.
REQ-008 The block SHALL have port req_op2_i  input  NUM_REQ x BIT_NUM  per-requester second operand.
REQ-009 The block SHALL have port req_sub_i  input  NUM_REQ  per-requester operation select: 0 add, 1 subtract.
REQ-010 The block SHALL have port rsp_valid_o  output  1  response slot holds a result.
REQ-011 The block SHALL have port rsp_ready_i  input  1  consumer accepts the response.
REQ-012 The block SHALL have port rsp_id_o  output  max(1,$clog2(NUM_REQ))  index of the requester that owns the response.
REQ-013 The block SHALL have port rsp_sum_o  output  BIT_NUM  registered result.
REQ-014 The block SHALL have port rsp_carry_o  output  1  registered carry out of the MSB.

Function
REQ-015 The block SHALL contain exactly one shared combinational ripple-carry adder, fed by a grant multiplexer.
REQ-016 Arithmetic SHALL be sum = op1 + (op2 XOR {BIT_NUM{sub}}) + sub, modulo 2^BIT_NUM; carry = bit BIT_NUM of that full-width sum (sub=1 with op1>=op2 gives carry=1).
REQ-017 The response slot SHALL be a two-state FSM: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1).
REQ-018 The slot SHALL be free in a cycle when state is EMPTY, or FULL with rsp_ready_i=1.
REQ-019 Arbitration SHALL be round-robin: the granted requester is the first i with req_valid_i[i]=1 scanning from pointer rr_ptr upward, wrapping from NUM_REQ-1 to 0.
REQ-020 req_ready_o[g] SHALL be 1 only for the granted index g and only when the slot is free; all other bits 0; all 0 when no req_valid_i bit is set.
REQ-021 A transfer SHALL occur when req_valid_i[g] and req_ready_o[g] are both 1; the result, carry and g are loaded into the slot at that edge (latency 1 cycle) and state becomes FULL.
REQ-022 On a transfer rr_ptr SHALL advance to (g+1) mod NUM_REQ; otherwise rr_ptr SHALL hold.
REQ-023 FULL with rsp_ready_i=1 and no transfer SHALL go to EMPTY; FULL with rsp_ready_i=1 and a transfer SHALL remain FULL with new contents (back-to-back, one result per cycle).
REQ-024 FULL with rsp_ready_i=0 SHALL hold rsp_sum_o, rsp_carry_o, rsp_id_o and rsp_valid_o stable, with req_ready_o all 0.
REQ-025 req_ready_o SHALL depend combinationally on req_valid_i, rr_ptr, state and rsp_ready_i only, never on operands.
REQ-026 A requester deasserting req_valid_i before transfer SHALL simply lose arbitration; no state changes.

Reset
REQ-027 While rst_i=1 at a rising edge, state SHALL become EMPTY, rr_ptr 0, rsp_sum_o 0, rsp_carry_o 0, rsp_id_o 0.
REQ-028 While rst_i=1, req_ready_o SHALL be all 0 and no transfer SHALL occur; a pending FULL response SHALL be discarded.
REQ-029 The first cycle after rst_i deasserts SHALL arbitrate with rr_ptr=0.

Verification
REQ-030 Add: BIT_NUM=4, req0 op1=3 op2=5 sub=0, slot EMPTY -> req_ready_o=0001 same cycle; next cycle rsp_valid_o=1, id=0, sum=8, carry=0.
REQ-031 Subtract/overflow: req1 5-3 -> sum=2 carry=1; 3-5 -> sum=14 carry=0; 15+1 add -> sum=0 carry=1.
REQ-032 Round-robin: all four req_valid_i=1 continuously, rsp_ready_i=1 -> rsp_id_o 0,1,2,3,0 on consecutive cycles, rsp_valid_o never drops.
REQ-033 Backpressure: slot FULL (id=2, sum=9), rsp_ready_i=0 for 3 cycles with req3 valid -> req_ready_o=0000, outputs unchanged; rsp_ready_i=1 -> req3 accepted that cycle, next cycle id=3.
REQ-034 Reset mid-operation: slot FULL, rr_ptr=2, rst_i=1 one cycle -> rsp_valid_o=0, sum=0; then req1 and req3 valid -> req1 granted first.
REQ-035 Idle drain: single response, rsp_ready_i=1, no requests -> rsp_valid_o=0 next cycle, rr_ptr unchanged.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Round-robin arbiter in front of a single shared ripple-carry adder/subtractor.
//   The winning requester's operands go through one adder, and the result is
//   captured into a one-entry response slot (EMPTY/FULL). A new request can be
//   accepted in the same cycle that the consumer drains the slot, so throughput
//   is one result per cycle.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   req_valid_i  : [NUM_REQ] request valid per requester
//   req_ready_o  : [NUM_REQ] accept; one-hot on the granted requester when the slot is free
//   req_op1_i    : [NUM_REQ][BIT_NUM] first operand per requester
//   req_op2_i    : [NUM_REQ][BIT_NUM] second operand per requester
//   req_sub_i    : [NUM_REQ] 0 = add, 1 = subtract
//   rsp_valid_o  : the slot holds a result
//   rsp_ready_i  : the consumer takes the response
//   rsp_id_o     : index of the requester that owns the response
//   rsp_sum_o    : registered result
//   rsp_carry_o  : registered carry out of the MSB

// Ripple-carry adder with carry-in. Subtraction is formed by the caller as
// a + ~b + 1.
module adder_arbiter_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end
endmodule

module adder_arbiter #(
  parameter int BIT_NUM = 4,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0][BIT_NUM-1:0]   req_op1_i,
  input  logic [NUM_REQ-1:0][BIT_NUM-1:0]   req_op2_i,
  input  logic [NUM_REQ-1:0]                req_sub_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [ID_W-1:0]                   rsp_id_o,
  output logic [BIT_NUM-1:0]                rsp_sum_o,
  output logic                              rsp_carry_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [BIT_NUM-1:0] sum;
    logic               carry;
  } rsp_t;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  rsp_t            rsp_q, rsp_d;

  // ---------------- arbitration ----------------
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic            slot_free;
  logic            xfer;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
  end

  assign slot_free = (state_q == EMPTY) || rsp_ready_i;

  // Ready never looks at operands; reset masks it so nothing transfers.
  assign req_ready_o = (gnt_found && slot_free && !rst_i)
                       ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign xfer = |(req_valid_i & req_ready_o);

  // ---------------- shared datapath ----------------
  logic [BIT_NUM-1:0] mux_op1, mux_op2, add_b, add_sum;
  logic               mux_sub, add_cout;

  assign mux_op1 = req_op1_i[gnt_idx];
  assign mux_op2 = req_op2_i[gnt_idx];
  assign mux_sub = req_sub_i[gnt_idx];
  assign add_b   = mux_op2 ^ {BIT_NUM{mux_sub}};

  adder_arbiter_rca #(.W(BIT_NUM)) u_rca (
    .a_i    (mux_op1),
    .b_i    (add_b),
    .cin_i  (mux_sub),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // ---------------- slot FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL:  if (rsp_ready_i && !xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    rsp_valid_o = (state_q == FULL);
  end

  // ---------------- pointer and payload ----------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    rsp_d    = rsp_q;
    if (xfer) begin
      rr_ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      rsp_d.id    = gnt_idx;
      rsp_d.sum   = add_sum;
      rsp_d.carry = add_cout;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      rsp_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rsp_q    <= rsp_d;
    end
  end

  assign rsp_id_o    = rsp_q.id;
  assign rsp_sum_o   = rsp_q.sum;
  assign rsp_carry_o = rsp_q.carry;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int BIT_NUM = 4;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [NUM_REQ-1:0]              req_valid;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0][BIT_NUM-1:0] op1, op2;
  logic [NUM_REQ-1:0]              sub;
  logic                            rsp_valid, rsp_ready, rsp_carry;
  logic [ID_W-1:0]                 rsp_id;
  logic [BIT_NUM-1:0]              rsp_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.BIT_NUM(BIT_NUM), .NUM_REQ(NUM_REQ)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op1_i   (op1),
    .req_op2_i   (op2),
    .req_sub_i   (sub),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_carry_o (rsp_carry)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
    op1 = '0; op2 = '0; sub = '0;
    tick(); tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_sum !== 4'd0 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL rst_regs got sum=%0d c=%b id=%0d exp 0/0/0", rsp_sum, rsp_carry, rsp_id); end
    rst = 1'b0; req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b exp 0", rsp_valid); end
  endtask

  task automatic test_add();
    req_valid = 4'b0001; op1[0] = 4'd3; op2[0] = 4'd5; sub[0] = 1'b0; rsp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 4'd8 || rsp_carry !== 1'b0) begin
      errors++; $display("FAIL add_rsp got v=%b id=%0d sum=%0d c=%b exp 1/0/8/0", rsp_valid, rsp_id, rsp_sum, rsp_carry); end
  endtask

  // Slot is FULL from test_add, rr_ptr=1; consumer drains each cycle.
  task automatic test_sub_overflow();
    logic [3:0] a [3];
    logic [3:0] b [3];
    logic       s [3];
    logic [3:0] es [3];
    logic       ec [3];
    a = '{4'd5, 4'd3, 4'd15}; b = '{4'd3, 4'd5, 4'd1}; s = '{1'b1, 1'b1, 1'b0};
    es = '{4'd2, 4'd14, 4'd0}; ec = '{1'b1, 1'b0, 1'b1};
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid = 4'b0010; op1[1] = a[k]; op2[1] = b[k]; sub[1] = s[k];
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sub_ready[%0d] got %b exp 0010", k, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== es[k] || rsp_carry !== ec[k]) begin
        errors++; $display("FAIL sub_rsp[%0d] got v=%b id=%0d sum=%0d c=%b exp 1/1/%0d/%b",
                           k, rsp_valid, rsp_id, rsp_sum, rsp_carry, es[k], ec[k]); end
    end
    // Idle drain: no requests, consumer ready -> slot empties, pointer stays at 2.
    req_valid = '0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", rsp_valid); end
    req_valid = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL drain_ptr got %b exp 0100", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op1[i] = BIT_NUM'(i); op2[i] = 4'd1; sub[i] = 1'b0;
    end
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << (k % 4))) begin
        errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'b0001 << (k % 4)); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(k % 4) || rsp_sum !== BIT_NUM'(k % 4 + 1)) begin
        errors++; $display("FAIL rr_rsp[%0d] got v=%b id=%0d sum=%0d exp 1/%0d/%0d",
                           k, rsp_valid, rsp_id, rsp_sum, k % 4, k % 4 + 1); end
    end
  endtask

  // rr_ptr=1 on entry, slot FULL.
  task automatic test_backpressure();
    req_valid = 4'b0100; op1[2] = 4'd4; op2[2] = 4'd5; sub[2] = 1'b0; rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_load_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b1000; op1[3] = 4'd7; op2[3] = 4'd2; sub[3] = 1'b1; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", k, req_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 4'd9 || rsp_carry !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b id=%0d sum=%0d c=%b exp 1/2/9/0",
                           k, rsp_valid, rsp_id, rsp_sum, rsp_carry); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_release_ready got %b exp 1000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 4'd5 || rsp_carry !== 1'b1) begin
      errors++; $display("FAIL bp_release_rsp got v=%b id=%0d sum=%0d c=%b exp 1/3/5/1",
                         rsp_valid, rsp_id, rsp_sum, rsp_carry); end
  endtask

  // rr_ptr=0 on entry; grant req1 to move it to 2, then reset.
  task automatic test_reset_mid();
    req_valid = 4'b0010; op1[1] = 4'd1; op2[1] = 4'd1; sub[1] = 1'b0; rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 4'd2) begin
      errors++; $display("FAIL mid_setup got v=%b id=%0d sum=%0d exp 1/1/2", rsp_valid, rsp_id, rsp_sum); end
    rsp_ready = 1'b0; rst = 1'b1; req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || rsp_sum !== 4'd0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL mid_rst_regs got v=%b sum=%0d id=%0d exp 0/0/0", rsp_valid, rsp_sum, rsp_id); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_first_grant got %b exp 0010", req_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
      errors++; $display("FAIL mid_first_rsp got v=%b id=%0d exp 1/1", rsp_valid, rsp_id); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
